// File: rtl/sig_dump_unit.sv
// sig_dump_unit: dumps RAM words [SIG_BEGIN, SIG_END) over the host port onto the sig_* stream.
// Latency: 3 cycles per word minimum (REQ/RESP/OUT); register responses arrive one cycle after dev_req_i.
// Backpressure: sig_ready_i low holds the word and blocks the next read; SIG_DUMP_CHECKSUM_EN adds CHECKSUM at 0x10.
module sig_dump_unit #(
   parameter int AddrWidth = 32,
   parameter int MaxWords  = 4096,
   parameter int IdxWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 dev_req_i,
   input  logic                 dev_we_i,
   input  logic [AddrWidth-1:0] dev_addr_i,
   input  logic [3:0]           dev_be_i,
   input  logic [31:0]          dev_wdata_i,
   output logic                 dev_rvalid_o,
   output logic [31:0]          dev_rdata_o,
   output logic                 dev_err_o,
   output logic                 host_req_o,
   input  logic                 host_gnt_i,
   output logic [AddrWidth-1:0] host_addr_o,
   output logic                 host_we_o,
   input  logic                 host_rvalid_i,
   input  logic [31:0]          host_rdata_i,
   input  logic                 host_err_i,
   output logic                 sig_valid_o,
   input  logic                 sig_ready_i,
   output logic [31:0]          sig_data_o,
   output logic [IdxWidth-1:0]  sig_index_o,
   output logic                 done_o,
   output logic                 err_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_RESP, S_OUT, S_DONE, S_ERR
   } state_t;

   state_t               state_q, state_d;
   logic [AddrWidth-1:0] sig_begin_q, sig_end_q, addr_q;
   logic [IdxWidth-1:0]  count_q;
   logic [31:0]          data_q;
`ifdef SIG_DUMP_CHECKSUM_EN
   logic [31:0]          csum_q;
`endif

   logic                 dev_rvalid_q, dev_err_q;
   logic [31:0]          dev_rdata_q;

   logic                 busy, full_be, acc_err, wr_begin, wr_end, start;
   logic [2:0]           reg_sel;
   logic [31:0]          rd_val, status;
   logic [15:0]          count16;
   logic [AddrWidth-1:0] span;
   logic                 cfg_bad, cfg_empty, last_word;
   logic                 unused_addr;

   assign busy        = (state_q == S_REQ) || (state_q == S_RESP) || (state_q == S_OUT);
   assign full_be     = (dev_be_i == 4'hF);
   assign reg_sel     = dev_addr_i[4:2];
   assign count16     = 16'(count_q);
   assign status      = {count16, 13'b0, err_o, done_o, busy};
   assign unused_addr = ^{dev_addr_i[AddrWidth-1:5], dev_addr_i[1:0]};

   // Range validation looks at the registers as they stand when START lands.
   assign span      = sig_end_q - sig_begin_q;
   assign cfg_bad   = (|sig_begin_q[1:0]) || (|sig_end_q[1:0]) || (sig_end_q < sig_begin_q) ||
                      ((span >> 2) > AddrWidth'(MaxWords));
   assign cfg_empty = (sig_end_q == sig_begin_q);
   assign last_word = ((addr_q + AddrWidth'(4)) == sig_end_q);

   always_comb begin
      acc_err  = 1'b0;
      rd_val   = 32'h0;
      wr_begin = 1'b0;
      wr_end   = 1'b0;
      start    = 1'b0;
      if (dev_req_i) begin
         if (dev_we_i && !full_be) begin
            acc_err = 1'b1;
         end else begin
            case (reg_sel)
               3'd0: begin
                  rd_val = 32'(sig_begin_q);
                  if (dev_we_i) begin
                     if (busy) acc_err = 1'b1;
                     else      wr_begin = 1'b1;
                  end
               end
               3'd1: begin
                  rd_val = 32'(sig_end_q);
                  if (dev_we_i) begin
                     if (busy) acc_err = 1'b1;
                     else      wr_end = 1'b1;
                  end
               end
               3'd2: begin
                  if (dev_we_i) begin
                     if (busy) acc_err = 1'b1;
                     else      start = dev_wdata_i[0];
                  end
               end
               3'd3: rd_val = status;
`ifdef SIG_DUMP_CHECKSUM_EN
               3'd4: rd_val = csum_q;
`else
               3'd4: acc_err = 1'b1;
`endif
               default: acc_err = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dev_rvalid_q <= 1'b0;
         dev_err_q    <= 1'b0;
         dev_rdata_q  <= 32'h0;
      end else begin
         dev_rvalid_q <= dev_req_i;
         dev_err_q    <= dev_req_i && acc_err;
         dev_rdata_q  <= (dev_req_i && !dev_we_i && !acc_err) ? rd_val : 32'h0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         sig_begin_q <= '0;
         sig_end_q   <= '0;
         addr_q      <= '0;
         count_q     <= '0;
         data_q      <= 32'h0;
`ifdef SIG_DUMP_CHECKSUM_EN
         csum_q      <= 32'h0;
`endif
      end else begin
         state_q <= state_d;
         if (wr_begin) sig_begin_q <= AddrWidth'(dev_wdata_i);
         if (wr_end)   sig_end_q   <= AddrWidth'(dev_wdata_i);
         if (start) begin
            addr_q  <= sig_begin_q;
            count_q <= '0;
`ifdef SIG_DUMP_CHECKSUM_EN
            csum_q  <= 32'h0;
`endif
         end else if (state_q == S_OUT && sig_ready_i) begin
            count_q <= count_q + IdxWidth'(1);
            addr_q  <= addr_q + AddrWidth'(4);
`ifdef SIG_DUMP_CHECKSUM_EN
            csum_q  <= csum_q + data_q;
`endif
         end
         if (state_q == S_RESP && host_rvalid_i && !host_err_i) data_q <= host_rdata_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      host_req_o  = 1'b0;
      sig_valid_o = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            done_o = (state_q == S_DONE);
            err_o  = (state_q == S_ERR);
            if (start) begin
               if (cfg_bad)        state_d = S_ERR;
               else if (cfg_empty) state_d = S_DONE;
               else                state_d = S_REQ;
            end
         end
         S_REQ: begin
            host_req_o = 1'b1;
            if (host_gnt_i) state_d = S_RESP;
         end
         S_RESP: begin
            if (host_rvalid_i) state_d = host_err_i ? S_ERR : S_OUT;
         end
         S_OUT: begin
            sig_valid_o = 1'b1;
            if (sig_ready_i) state_d = last_word ? S_DONE : S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign host_addr_o  = addr_q;
   assign host_we_o    = 1'b0;
   assign sig_data_o   = data_q;
   assign sig_index_o  = count_q;
   assign dev_rvalid_o = dev_rvalid_q;
   assign dev_rdata_o  = dev_rdata_q;
   assign dev_err_o    = dev_err_q;

endmodule

// File: doc/sig_dump_unit.md
Name: sig_dump_unit

Overview:
Signature dump engine for the compliance harness. Attaches to the harness bus as both a device and a host. Software programs the signature begin and end addresses and then writes START. The unit then reads each signature word from RAM through its host port and streams the words out on a valid/ready interface to the simulation top, which writes the signature file. This stage sits directly downstream of the harness RAM/bus and consumes what the compliance program produced.

Parameters:
- AddrWidth, 32, bus address width.
- MaxWords, 4096, maximum signature length in words; longer ranges are an error.
- IdxWidth, 16, width of the emitted word index; must satisfy 2**IdxWidth >= MaxWords.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- dev_req_i  in  1  device request; always accepted, since the bus handles grant.
- dev_we_i  in  1  device write enable.
- dev_addr_i  in  AddrWidth  device address; only bits [4:2] are decoded.
- dev_be_i  in  4  byte enables; register writes require 4'hF.
- dev_wdata_i  in  32  write data.
- dev_rvalid_o  out  1  response valid, exactly one cycle after dev_req_i.
- dev_rdata_o  out  32  read data.
- dev_err_o  out  1  error response, qualified by dev_rvalid_o.
- host_req_o  in/out: out  1  host read request.
- host_gnt_i  in  1  grant.
- host_addr_o  out  AddrWidth  read address.
- host_we_o  out  1  tied 0.
- host_rvalid_i  in  1  read data valid.
- host_rdata_i  in  32  read data.
- host_err_i  in  1  bus error, qualified by host_rvalid_i.
- sig_valid_o  out  1  signature word valid.
- sig_ready_i  in  1  consumer ready.
- sig_data_o  out  32  signature word.
- sig_index_o  out  IdxWidth  word index, starting at 0.
- done_o  out  1  dump finished; level output, cleared by the next START.
- err_o  out  1  dump aborted; level output, cleared by the next START.

Behaviour:
- Reset: the following outputs are 0: all outputs, SIG_BEGIN, SIG_END, count, checksum. FSM is in IDLE.
- Register map (offset = dev_addr_i[4:0]):
  - 0x00 SIG_BEGIN (RW).
  - 0x04 SIG_END (RW, exclusive).
  - 0x08 CTRL: write bit0 = START; reads return 0.
  - 0x0C STATUS (RO): {count[15:0], 13'b0, err, done, busy}.
- Error responses (dev_err_o=1):
  - Any other offset.
  - Partial dev_be_i on a write.
  - A write to SIG_BEGIN, SIG_END or CTRL while busy; the register value is unchanged.
  - Error reads return 0.
- START validation, performed in IDLE/DONE/ERR:
  - SIG_BEGIN[1:0]!=0, SIG_END[1:0]!=0, SIG_END<SIG_BEGIN, or (SIG_END-SIG_BEGIN)>>2 > MaxWords → go to ERR next cycle with err_o=1 and no bus traffic.
  - SIG_END==SIG_BEGIN → go to DONE next cycle with count=0 and no bus traffic.
  - Otherwise load addr=SIG_BEGIN, clear count, go to REQ.
- FSM states and transitions:
  - IDLE: waits for START.
  - REQ: host_req_o=1 and host_addr_o=addr, held stable until host_gnt_i. On grant → RESP.
  - RESP: host_req_o=0; waits for host_rvalid_i.
    - host_err_i=1 → ERR.
    - Otherwise capture data into the output register → OUT.
  - OUT: sig_valid_o=1 with data and index stable until sig_ready_i.
    - On handshake: count++, addr+=4.
    - If addr+4==SIG_END → DONE, else → REQ.
  - DONE: done_o=1; waits for START.
  - ERR: err_o=1; waits for START.
- Outstanding reads: at most one; no new request is issued until the current word is accepted.
- Minimum throughput: 3 cycles per word (REQ→RESP→OUT) with immediate gnt, rvalid and ready.
- Bus timing tolerance: host_rvalid_i may arrive any number of cycles after grant. host_rvalid_i outside RESP is ignored.
- Simultaneous events: a device access in the same cycle as a host response is legal; both ports operate independently.
- Reset mid-dump: everything returns to reset values immediately, asynchronously. No further host_req_o is issued.

Optional Feature:
- Macro: SIG_DUMP_CHECKSUM_EN.
- Defined: offset 0x10 CHECKSUM (RO) holds a running 32-bit sum, modulo 2^32, of every word accepted on the sig interface. It is cleared on START.
- Undefined: offset 0x10 is unmapped and returns rdata 0 with dev_err_o=1.

Test Plan:
- Basic dump: SIG_BEGIN=0x1000, SIG_END=0x1010, RAM words {0x11,0x22,0x33,0x44}, ready tied 1 → 4 sig transfers with indices 0..3 and matching data; done_o=1; STATUS=0x0004_0002. Checksum variant: CHECKSUM=0xAA.
- Empty range: BEGIN=END=0x2000, START → done_o=1 the next cycle; host_req_o never asserted; count=0.
- Bad configs:
  - BEGIN=0x1002 → err_o=1.
  - END<BEGIN → err_o=1.
  - Range of MaxWords+1 words → err_o=1.
  - None of these produce a host request.
- Backpressure and delays: ready low for 5 cycles on word 1, gnt delayed 3 cycles, rvalid delayed 4 cycles → data, index and host_addr_o held stable; exactly 4 words; no duplicates.
- Bus error: host_err_i=1 on word 2 of 4 → err_o=1; only words 0..1 emitted; STATUS count=2.
- Register access errors:
  - Write SIG_END while busy → dev_err_o=1 and the value is unchanged.
  - Read offset 0x14 → dev_err_o=1 and rdata=0.
  - Assert rst_i during OUT → all outputs 0 in the same cycle; FSM in IDLE.
